// File: rtl/ascii_number_parser.sv
// ---------------------------------------------------------------------------
// ascii_number_parser
//
// Parses an optionally signed ASCII decimal number from a UART byte stream.
// A number is terminated by CR, LF or space. On success a two's-complement
// result is published with a one-cycle value_valid pulse. A rejected number
// gives a one-cycle parse_error pulse, and err_code reports the cause.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   rx_data      received byte, qualified by new_rx_data
//   new_rx_data  one-cycle strobe per received byte
//   value        signed parsed result, held until the next value_valid
//   value_valid  one-cycle pulse: value updated this cycle
//   parse_error  one-cycle pulse: number rejected
//   err_code     0 none, 1 BADCHAR, 2 OVERFLOW, 3 EMPTY
//   busy         high while a number is in progress or being discarded
// ---------------------------------------------------------------------------
module ascii_number_parser #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    new_rx_data,
  output logic signed [WIDTH-1:0] value,
  output logic                    value_valid,
  output logic                    parse_error,
  output logic [1:0]              err_code,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, SIGN, ACCUM, DISCARD} state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BADCHAR  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_EMPTY    = 2'd3;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Four extra bits hold acc*10+9 for the largest accumulator (2^(WIDTH-1)).
  localparam int AW = WIDTH + 4;

  state_t                   state, state_nx;
  logic [WIDTH-1:0]         acc, acc_nx;
  logic [CW-1:0]            count, count_nx;
  logic                     neg, neg_nx;
  logic signed [WIDTH-1:0]  value_nx;
  logic                     value_valid_nx, parse_error_nx;
  logic [1:0]               err_code_nx;
  logic                     err_hit;
  logic [1:0]               err_cause;

  // Byte classification.
  logic       is_digit, is_term, is_sign;
  logic [3:0] digit;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h20);
  assign is_sign  = (rx_data == 8'h2D) || (rx_data == 8'h2B);
  assign digit    = rx_data[3:0];

  // Candidate accumulator value, acc*10 + d, and the sign-dependent limit.
  logic [AW-1:0] acc_ext, acc_next, limit;

  assign acc_ext  = {4'b0000, acc};
  assign acc_next = (acc_ext << 3) + (acc_ext << 1) + AW'(digit);
  assign limit    = neg ? (AW'(1) << (WIDTH - 1))
                        : (AW'(1) << (WIDTH - 1)) - AW'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments, so every flop samples the
    // pre-edge values and the order of statements in this block does not matter.
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      neg         <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      parse_error <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_nx;
      acc         <= acc_nx;
      count       <= count_nx;
      neg         <= neg_nx;
      value       <= value_nx;
      value_valid <= value_valid_nx;
      parse_error <= parse_error_nx;
      err_code    <= err_code_nx;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    // NOTE: every signal assigned below gets a default here first. A path that
    // left one of them unassigned would infer a latch.
    state_nx       = state;
    acc_nx         = acc;
    count_nx       = count;
    neg_nx         = neg;
    value_nx       = value;
    value_valid_nx = 1'b0;
    parse_error_nx = 1'b0;
    err_code_nx    = err_code;
    err_hit        = 1'b0;
    err_cause      = ERR_NONE;

    if (new_rx_data) begin
      unique case (state)
        IDLE: begin
          if (is_digit) begin
            state_nx = ACCUM;
            acc_nx   = WIDTH'(digit);
            count_nx = CW'(1);
            neg_nx   = 1'b0;
          end else if (is_sign) begin
            state_nx = SIGN;
            neg_nx   = rx_data[1] == 1'b0; // '-' is 0x2D, '+' is 0x2B
          end else if (!is_term) begin
            state_nx  = DISCARD;
            err_hit   = 1'b1;
            err_cause = ERR_BADCHAR;
          end
        end
        SIGN: begin
          if (is_digit) begin
            state_nx = ACCUM;
            acc_nx   = WIDTH'(digit);
            count_nx = CW'(1);
          end else if (is_term) begin
            state_nx  = IDLE;
            err_hit   = 1'b1;
            err_cause = ERR_EMPTY;
          end else begin
            state_nx  = DISCARD;
            err_hit   = 1'b1;
            err_cause = ERR_BADCHAR;
          end
        end
        ACCUM: begin
          if (is_digit) begin
            if (count == CW'(MAX_DIGITS) || acc_next > limit) begin
              state_nx  = DISCARD;
              err_hit   = 1'b1;
              err_cause = ERR_OVERFLOW;
            end else begin
              acc_nx   = acc_next[WIDTH-1:0];
              count_nx = count + CW'(1);
            end
          end else if (is_term) begin
            // The negated magnitude wraps correctly for -2^(WIDTH-1).
            state_nx       = IDLE;
            value_nx       = neg ? $signed(-acc) : $signed(acc);
            value_valid_nx = 1'b1;
            err_code_nx    = ERR_NONE;
            acc_nx         = '0;
            count_nx       = '0;
            neg_nx         = 1'b0;
          end else begin
            state_nx  = DISCARD;
            err_hit   = 1'b1;
            err_cause = ERR_BADCHAR;
          end
        end
        DISCARD: begin
          if (is_term) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase

      if (err_hit) begin
        parse_error_nx = 1'b1;
        err_code_nx    = err_cause;
        acc_nx         = '0;
        count_nx       = '0;
        neg_nx         = 1'b0;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_ascii_number_parser.sv
module tb_ascii_number_parser;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         rx_data;
  logic               new_rx_data;
  logic signed [31:0] value;
  logic               value_valid;
  logic               parse_error;
  logic [1:0]         err_code;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // What happened while a string was sent.
  int       vv_cnt, pe_cnt, vv_pos, pe_pos;
  logic [1:0] pe_err;
  bit       busy_seen, busy_last;

  ascii_number_parser #(.WIDTH(32), .MAX_DIGITS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .value       (value),
    .value_valid (value_valid),
    .parse_error (parse_error),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge. Each byte is sampled on the next rising
  // edge, and its result is read on the falling edge after that.
  task automatic send_str(input string s, input int gap);
    vv_cnt = 0; pe_cnt = 0; vv_pos = -1; pe_pos = -1; pe_err = 2'd0;
    busy_seen = 1'b0; busy_last = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      rx_data     = s[i];
      new_rx_data = 1'b1;
      @(negedge clk);
      new_rx_data = 1'b0;
      if (value_valid) begin vv_cnt++; vv_pos = i; end
      if (parse_error) begin pe_cnt++; pe_pos = i; pe_err = err_code; end
      busy_seen = busy_seen | busy;
      busy_last = busy;
      if (i != s.len() - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (value_valid) vv_cnt++;
          if (parse_error) pe_cnt++;
          busy_seen = busy_seen | busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; new_rx_data = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 32'sd0 || value_valid !== 1'b0 || parse_error !== 1'b0 ||
        err_code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got value=%0d vv=%b pe=%b err=%0d busy=%b, want all 0",
               value, value_valid, parse_error, err_code, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_str("123\r", 4);
    checks++;
    if (vv_cnt != 1 || vv_pos != 3 || pe_cnt != 0) begin
      errors++;
      $display("FAIL basic_pulse: got vv_cnt=%0d vv_pos=%0d pe_cnt=%0d, want 1 3 0", vv_cnt, vv_pos, pe_cnt);
    end
    checks++;
    if (value !== 32'sd123 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL basic_value: got %0d err=%0d, want 123 err=0", value, err_code);
    end
    checks++;
    if (busy_seen !== 1'b1 || busy_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got seen=%b last=%b, want 1 0", busy_seen, busy_last);
    end
    @(negedge clk);
    checks++;
    if (value_valid !== 1'b0 || value !== 32'sd123) begin
      errors++;
      $display("FAIL basic_pulse_width: got vv=%b value=%0d, want 0 123", value_valid, value);
    end
    send_str("-0\r", 1);
    checks++;
    if (vv_cnt != 1 || value !== 32'sd0) begin
      errors++;
      $display("FAIL neg_zero: got vv_cnt=%0d value=%0d, want 1 0", vv_cnt, value);
    end
    send_str("-5 3 ", 0);
    checks++;
    if (vv_cnt != 2 || value !== 32'sd3) begin
      errors++;
      $display("FAIL sign_cleared: got vv_cnt=%0d value=%0d, want 2 3", vv_cnt, value);
    end
  endtask

  task automatic test_back_to_back();
    send_str("-2147483648 ", 0);
    checks++;
    if (vv_cnt != 1 || vv_pos != 11 || value !== 32'sh80000000) begin
      errors++;
      $display("FAIL min_value: got vv_cnt=%0d pos=%0d value=%h, want 1 11 80000000", vv_cnt, vv_pos, value);
    end
    send_str("2147483647\n", 0);
    checks++;
    if (vv_cnt != 1 || pe_cnt != 0 || value !== 32'sh7FFFFFFF) begin
      errors++;
      $display("FAIL max_value: got vv_cnt=%0d pe_cnt=%0d value=%h, want 1 0 7fffffff", vv_cnt, pe_cnt, value);
    end
  endtask

  task automatic test_overflow();
    send_str("2147483648\n", 0);
    checks++;
    if (pe_cnt != 1 || pe_pos != 9 || pe_err !== 2'd2 || vv_cnt != 0) begin
      errors++;
      $display("FAIL overflow_value: got pe_cnt=%0d pos=%0d err=%0d vv_cnt=%0d, want 1 9 2 0",
               pe_cnt, pe_pos, pe_err, vv_cnt);
    end
    checks++;
    if (value !== 32'sh7FFFFFFF || err_code !== 2'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_hold: got value=%h err=%0d busy=%b, want 7fffffff 2 0", value, err_code, busy);
    end
    send_str("5\n", 2);
    checks++;
    if (vv_cnt != 1 || value !== 32'sd5 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL after_overflow: got vv_cnt=%0d value=%0d err=%0d, want 1 5 0", vv_cnt, value, err_code);
    end
  endtask

  task automatic test_errors();
    send_str("-\r", 0);
    checks++;
    if (pe_cnt != 1 || pe_pos != 1 || pe_err !== 2'd3 || busy_last !== 1'b0) begin
      errors++;
      $display("FAIL empty: got pe_cnt=%0d pos=%0d err=%0d busy=%b, want 1 1 3 0", pe_cnt, pe_pos, pe_err, busy_last);
    end
    send_str("12a4\r", 0);
    checks++;
    if (pe_cnt != 1 || pe_pos != 2 || pe_err !== 2'd1 || vv_cnt != 0 || busy_last !== 1'b0) begin
      errors++;
      $display("FAIL badchar: got pe_cnt=%0d pos=%0d err=%0d vv_cnt=%0d busy=%b, want 1 2 1 0 0",
               pe_cnt, pe_pos, pe_err, vv_cnt, busy_last);
    end
    send_str("  \n", 1);
    checks++;
    if (pe_cnt != 0 || vv_cnt != 0 || busy_seen !== 1'b0 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL terminators_only: got pe_cnt=%0d vv_cnt=%0d busy_seen=%b err=%0d, want 0 0 0 1",
               pe_cnt, vv_cnt, busy_seen, err_code);
    end
    send_str("+-1\r", 0);
    checks++;
    if (pe_cnt != 1 || pe_pos != 1 || pe_err !== 2'd1 || vv_cnt != 0) begin
      errors++;
      $display("FAIL double_sign: got pe_cnt=%0d pos=%0d err=%0d vv_cnt=%0d, want 1 1 1 0",
               pe_cnt, pe_pos, pe_err, vv_cnt);
    end
  endtask

  task automatic test_max_digits();
    send_str("00000000001\r", 0);
    checks++;
    if (pe_cnt != 1 || pe_pos != 10 || pe_err !== 2'd2 || vv_cnt != 0) begin
      errors++;
      $display("FAIL eleven_digits: got pe_cnt=%0d pos=%0d err=%0d vv_cnt=%0d, want 1 10 2 0",
               pe_cnt, pe_pos, pe_err, vv_cnt);
    end
    send_str("0000000042\r", 0);
    checks++;
    if (vv_cnt != 1 || pe_cnt != 0 || value !== 32'sd42 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL ten_digits: got vv_cnt=%0d pe_cnt=%0d value=%0d err=%0d, want 1 0 42 0",
               vv_cnt, pe_cnt, value, err_code);
    end
  endtask

  task automatic test_reset_mid();
    send_str("x ", 0);
    send_str("45", 0);
    checks++;
    if (busy !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b err=%0d, want 1 1", busy, err_code);
    end
    // A terminator arriving during reset must be ignored.
    rst = 1'b1; rx_data = 8'h0D; new_rx_data = 1'b1;
    @(negedge clk);
    checks++;
    if (value !== 32'sd0 || value_valid !== 1'b0 || parse_error !== 1'b0 ||
        err_code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got value=%0d vv=%b pe=%b err=%0d busy=%b, want all 0",
               value, value_valid, parse_error, err_code, busy);
    end
    rst = 1'b0; new_rx_data = 1'b0;
    @(negedge clk);
    send_str("7\r", 0);
    checks++;
    if (vv_cnt != 1 || pe_cnt != 0 || value !== 32'sd7) begin
      errors++;
      $display("FAIL after_reset: got vv_cnt=%0d pe_cnt=%0d value=%0d, want 1 0 7", vv_cnt, pe_cnt, value);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_max_digits();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
